// File: rtl/sram_rd_arbiter.sv
// rtl/sram_rd_arbiter.sv - two-requester SRAM read arbiter onto a single AXI read channel
module sram_rd_arbiter #(
  parameter int MAX_OUTS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {S_IDLE, S_AR_BUSY} state_t;

  localparam logic [1:0] LP_MAX = 2'(MAX_OUTS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [3:0]  r_arid;
  logic [2:0]  r_arsize;
  logic        r_rready;
  logic [1:0]  r_inst_outs;
  logic [1:0]  r_data_outs;
  logic [1:0]  r_starve;

  logic w_inst_elig;
  logic w_data_elig;
  logic w_grant_inst;
  logic w_grant_data;
  logic w_hs;
  logic w_r_fire;
  logic w_inst_dec;
  logic w_data_dec;
  logic w_unused_rid;

  // Only rid[0] selects the requester; the upper ID bits carry no meaning here.
  assign w_unused_rid = ^rid[3:1];

  assign w_inst_elig = inst_req && (r_inst_outs < LP_MAX);
  assign w_data_elig = data_req && (r_data_outs < LP_MAX);

  // A beat for a requester with nothing outstanding is stale (e.g. pre-reset) and is dropped.
  assign w_r_fire   = rvalid && r_rready;
  assign w_inst_dec = w_r_fire && !rid[0] && (r_inst_outs != 2'd0);
  assign w_data_dec = w_r_fire &&  rid[0] && (r_data_outs != 2'd0);

  assign inst_addr_ok = w_hs && !r_arid[0] && inst_req;
  assign data_addr_ok = w_hs &&  r_arid[0] && data_req;
  assign inst_data_ok = w_inst_dec;
  assign data_data_ok = w_data_dec;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  // AR controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant selection in IDLE (data first unless inst has been starved 3 times) and handshake detect.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_inst_elig && (!w_data_elig || (r_starve == 2'd3))) w_grant_inst = 1'b1;
        else if (w_data_elig)                                    w_grant_data = 1'b1;
        if (w_grant_inst || w_grant_data) w_state_nxt = S_AR_BUSY;
      end
      S_AR_BUSY: begin
        if (r_arvalid && arready) begin
          w_hs        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // AR payload latched on grant and held untouched until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arvalid <= 1'b0;
      r_araddr  <= 32'd0;
      r_arid    <= 4'd0;
      r_arsize  <= 3'd0;
    end else if (w_grant_inst) begin
      r_arvalid <= 1'b1;
      r_araddr  <= inst_addr;
      r_arid    <= 4'd0;
      r_arsize  <= {1'b0, inst_size};
    end else if (w_grant_data) begin
      r_arvalid <= 1'b1;
      r_araddr  <= data_addr;
      r_arid    <= 4'd1;
      r_arsize  <= {1'b0, data_size};
    end else if (w_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  // rready comes up on the first edge after reset and stays up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rready <= 1'b0;
    else       r_rready <= 1'b1;
  end

  // Outstanding counters: +1 on addr_ok, -1 on accepted beat, both cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst_outs <= 2'd0;
      r_data_outs <= 2'd0;
    end else begin
      if (inst_addr_ok && !w_inst_dec)      r_inst_outs <= r_inst_outs + 2'd1;
      else if (!inst_addr_ok && w_inst_dec) r_inst_outs <= r_inst_outs - 2'd1;
      if (data_addr_ok && !w_data_dec)      r_data_outs <= r_data_outs + 2'd1;
      else if (!data_addr_ok && w_data_dec) r_data_outs <= r_data_outs - 2'd1;
    end
  end

  // Starvation counter: counts data acceptances while inst waits, cleared otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 2'd0;
    end else if (w_hs) begin
      if (r_arid[0] && inst_req) begin
        if (r_starve != 2'd3) r_starve <= r_starve + 2'd1;
      end else begin
        r_starve <= 2'd0;
      end
    end
  end

endmodule

// File: doc/sram_rd_arbiter.md
SRAM_RD_ARBITER -- requirements
Module: sram_rd_arbiter

Interface
REQ-001 Parameter MAX_OUTS, default 3: maximum outstanding reads per requester (1..3).
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction fetch read request.
- inst_addr  in  32  fetch physical address.
- inst_size  in  2  fetch size (log2 bytes).
- inst_addr_ok  out  1  fetch request accepted.
- inst_data_ok  out  1  fetch data returned.
- inst_rdata  out  32  fetch data.
- data_req / data_addr / data_size  in  1/32/2  load read request, same meaning as the inst_* inputs.
- data_addr_ok / data_data_ok / data_rdata  out  1/1/32  load-side equivalents of the inst_* outputs.
- arid  out  4  AXI read ID: 0 = inst, 1 = data.
- araddr  out  32  AXI read address.
- arsize  out  3  AXI read size.
- arlen  out  8  constant 0.
- arburst  out  2  constant 2'b01.
- arvalid  out  1  AXI address valid.
- arready  in  1  AXI address ready.
- rid  in  4  AXI read ID.
- rdata  in  32  AXI read data.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.

Function
REQ-003 The AR controller SHALL have two states, IDLE and AR_BUSY.
REQ-004 Grant rule in IDLE:
- a requester is eligible when its req=1 and its outstanding count < MAX_OUTS;
- data has priority over inst;
- exception: if the starvation counter = 3 and inst is eligible, inst wins.
REQ-005 On grant, the block SHALL:
- latch addr into araddr, {1'b0,size} into arsize, and the owner ID into arid;
- assert arvalid (registered) in the next cycle;
- move to AR_BUSY.
REQ-006 In AR_BUSY, arvalid and the AR payload SHALL stay stable until arvalid&arready.
REQ-007 On the handshake cycle, the owner's addr_ok SHALL be 1 (combinational from arready) and the FSM SHALL return to IDLE.
- Minimum spacing between grants is 2 cycles.
REQ-008 Requesters hold req/addr/size stable from req assertion until their addr_ok.
- The block SHALL never assert addr_ok to a requester whose req is currently 0.
REQ-009 Starvation counter (2 bits), updated per accepted AR:
- +1 (saturating at 3) when data is accepted while inst_req=1;
- cleared when inst is accepted or inst_req=0.
REQ-010 Outstanding counters (per requester, 2 bits):
- +1 on its addr_ok;
- -1 on an R beat with rvalid&rready and matching rid[0];
- unchanged when both occur in the same cycle.
REQ-011 An R beat arriving when the matching counter = 0 SHALL be dropped:
- no data_ok;
- no underflow.
REQ-012 rready SHALL be 0 during reset and 1 from the first cycle after reset deasserts.
REQ-013 R routing (zero latency):
- inst_data_ok = rvalid & rready & (rid[0]==0);
- data_data_ok = rvalid & rready & (rid[0]==1);
- inst_rdata = data_rdata = rdata.
REQ-014 addr_ok and data_ok for the same or different requesters SHALL be allowed in the same cycle without interaction.
REQ-015 rid[3:1] SHALL be ignored.
REQ-016 Out-of-order returns between IDs SHALL be supported; per-ID order is in issue order.

Reset
REQ-017 While reset=1, the block SHALL asynchronously force:
- FSM to IDLE;
- arvalid, rready, all addr_ok and all data_ok to 0;
- araddr = 0, arid = 0, arsize = 0;
- all counters to 0.
REQ-018 Reset asserted mid-transaction (AR_BUSY, or reads outstanding) SHALL abandon all state.
- No addr_ok or data_ok SHALL be produced for pre-reset requests.

Verification
REQ-019 The bench SHALL cover the following directed scenarios.
- Single fetch: inst_req=1 with addr 0x1C000000, arready=1 -> arvalid next cycle, arid=0, araddr=0x1C000000, inst_addr_ok on the handshake; then rvalid with rid=0, rdata=0x02800000 -> inst_data_ok=1, inst_rdata=0x02800000, same cycle.
- Priority: inst_req and data_req asserted together -> data granted first (arid=1), inst granted on the next IDLE grant.
- Starvation: data_req held continuously while inst_req=1 -> after 3 consecutive data grants, the 4th grant goes to inst (arid=0).
- Outstanding limit: with MAX_OUTS=3 and no R beats, 3 inst_addr_ok pulses occur, then no 4th until an rid=0 beat; simultaneous addr_ok and R beat leaves the count unchanged.
- Backpressure and reset: arready=0 for 5 cycles -> araddr/arid/arsize stable and arvalid held; reset pulse during AR_BUSY -> arvalid=0 immediately, and a later rvalid with rid=0 produces no inst_data_ok.
